// File: rtl/gray_step_if.sv
// rtl/gray_step_if.sv - Gray input bus and decoded step/position outputs
interface gray_step_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] gray_in;
    logic             clr_counts;
    logic [WIDTH-1:0] binary_out;
    logic             valid;
    logic             step_pulse;
    logic             step_up;
    logic             error_pulse;
    logic [15:0]      position;
    logic [7:0]       error_count;

    modport master (
        output gray_in,
        output clr_counts,
        input  binary_out,
        input  valid,
        input  step_pulse,
        input  step_up,
        input  error_pulse,
        input  position,
        input  error_count
    );

    modport slave (
        input  gray_in,
        input  clr_counts,
        output binary_out,
        output valid,
        output step_pulse,
        output step_up,
        output error_pulse,
        output position,
        output error_count
    );
endinterface

// File: rtl/gray_step_decoder.sv
// rtl/gray_step_decoder.sv - Synchronise, debounce and decode a Gray bus into steps
module gray_step_decoder #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 4
) (
    input  logic         clk,
    input  logic         rst,
    gray_step_if.slave   bus
);
    localparam int CW = $clog2(DEBOUNCE + 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] cand;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic [WIDTH-1:0] b_new;
    logic [WIDTH-1:0] diff;

    logic [WIDTH-1:0] bin_q;
    logic             valid_q;
    logic             step_pulse_q;
    logic             step_up_q;
    logic             error_pulse_q;
    logic [15:0]      position_q;
    logic [7:0]       error_count_q;

    function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Multi-flop synchroniser chain per bit for the asynchronous Gray bus
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= bus.gray_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    // Debounce: restart on any change, count up to DEBOUNCE and then hold
    always_ff @(posedge clk) begin
        if (rst) begin
            cand <= '0;
            cnt  <= '0;
        end else if (sync != cand) begin
            cand <= sync;
            cnt  <= '0;
        end else if (cnt < CW'(DEBOUNCE)) begin
            cnt <= cnt + CW'(1);
        end
    end

    // Acceptance fires once, on the edge the count would reach DEBOUNCE
    assign accept = (sync == cand) && (cnt == CW'(DEBOUNCE - 1));
    assign b_new  = gray_to_bin(cand);
    assign diff   = b_new - bin_q;

    // Classify each accepted code and update position, error count and pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q         <= '0;
            valid_q       <= 1'b0;
            step_pulse_q  <= 1'b0;
            step_up_q     <= 1'b0;
            error_pulse_q <= 1'b0;
            position_q    <= '0;
            error_count_q <= '0;
        end else begin
            step_pulse_q  <= 1'b0;
            error_pulse_q <= 1'b0;
            if (accept) begin
                if (!valid_q) begin
                    bin_q   <= b_new;
                    valid_q <= 1'b1;
                end else if (diff == '0) begin
                    // Glitch settled back on the current code: nothing to report
                end else if (diff == WIDTH'(1)) begin
                    bin_q        <= b_new;
                    step_pulse_q <= 1'b1;
                    step_up_q    <= 1'b1;
                    position_q   <= position_q + 16'd1;
                end else if (diff == {WIDTH{1'b1}}) begin
                    bin_q        <= b_new;
                    step_pulse_q <= 1'b1;
                    step_up_q    <= 1'b0;
                    position_q   <= position_q - 16'd1;
                end else begin
                    bin_q         <= b_new;
                    error_pulse_q <= 1'b1;
                    if (error_count_q != 8'hFF) begin
                        error_count_q <= error_count_q + 8'd1;
                    end
                end
            end
            // Clear wins over any coincident count update, later assignment takes effect
            if (bus.clr_counts) begin
                position_q    <= '0;
                error_count_q <= '0;
            end
        end
    end

    assign bus.binary_out  = bin_q;
    assign bus.valid       = valid_q;
    assign bus.step_pulse  = step_pulse_q;
    assign bus.step_up     = step_up_q;
    assign bus.error_pulse = error_pulse_q;
    assign bus.position    = position_q;
    assign bus.error_count = error_count_q;
endmodule

// File: tb/tb_gray_step_decoder.sv
// tb/tb_gray_step_decoder.sv - Directed self-checking bench for gray_step_decoder
module tb_gray_step_decoder;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    int   err_seen;
    int   both_seen;
    int   step_seen;

    gray_step_if #(.WIDTH(4)) bus ();

    gray_step_decoder #(
        .WIDTH(4),
        .SYNC_STAGES(2),
        .DEBOUNCE(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_bin"}, 32'(bus.binary_out), 32'd0);
        chk({tag, "_valid"}, 32'(bus.valid), 32'd0);
        chk({tag, "_step"}, 32'(bus.step_pulse), 32'd0);
        chk({tag, "_up"}, 32'(bus.step_up), 32'd0);
        chk({tag, "_err"}, 32'(bus.error_pulse), 32'd0);
        chk({tag, "_pos"}, 32'(bus.position), 32'd0);
        chk({tag, "_ecnt"}, 32'(bus.error_count), 32'd0);
    endtask

    // Drive a code held 20 cycles; a legal step must pulse exactly at edge 7
    task automatic do_step(input string tag, input logic [3:0] g, input logic [3:0] bin,
                           input logic up, input logic [15:0] pos);
        bus.gray_in = g;
        tick(6);
        chk({tag, "_early"}, 32'(bus.step_pulse), 32'd0);
        tick(1);
        chk({tag, "_pulse"}, 32'(bus.step_pulse), 32'd1);
        chk({tag, "_noerr"}, 32'(bus.error_pulse), 32'd0);
        chk({tag, "_bin"}, 32'(bus.binary_out), 32'(bin));
        chk({tag, "_up"}, 32'(bus.step_up), 32'(up));
        chk({tag, "_pos"}, 32'(bus.position), 32'(pos));
        tick(1);
        chk({tag, "_narrow"}, 32'(bus.step_pulse), 32'd0);
        tick(12);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        bus.gray_in = 4'b0000;
        bus.clr_counts = 1'b0;
        tick(2);
        chk_reset_vals("reset");

        // 1: valid rises on the fourth edge after reset release
        rst = 1'b0;
        tick(3);
        chk("valid_e3", 32'(bus.valid), 32'd0);
        tick(1);
        chk("valid_e4", 32'(bus.valid), 32'd1);
        chk("t1_bin", 32'(bus.binary_out), 32'd0);
        chk("t1_step", 32'(bus.step_pulse), 32'd0);
        chk("t1_err", 32'(bus.error_pulse), 32'd0);
        chk("t1_pos", 32'(bus.position), 32'd0);
        tick(10);

        // 2: three up steps
        do_step("up1", 4'b0001, 4'd1, 1'b1, 16'd1);
        do_step("up2", 4'b0011, 4'd2, 1'b1, 16'd2);
        do_step("up3", 4'b0010, 4'd3, 1'b1, 16'd3);

        // 3: walk down to zero, wrap below zero, wrap back up
        do_step("dn2", 4'b0011, 4'd2, 1'b0, 16'd2);
        do_step("dn1", 4'b0001, 4'd1, 1'b0, 16'd1);
        do_step("dn0", 4'b0000, 4'd0, 1'b0, 16'd0);
        do_step("wrap_dn", 4'b1000, 4'd15, 1'b0, 16'hFFFF);
        do_step("wrap_up", 4'b0000, 4'd0, 1'b1, 16'd0);

        // 4: debounce window boundary
        do_step("to1", 4'b0001, 4'd1, 1'b1, 16'd1);
        bus.gray_in = 4'b0011;
        tick(4);
        bus.gray_in = 4'b0001;
        step_seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (bus.step_pulse || bus.error_pulse) step_seen++;
        end
        chk("glitch4_nopulse", 32'(step_seen), 32'd0);
        chk("glitch4_bin", 32'(bus.binary_out), 32'd1);
        bus.gray_in = 4'b0011;
        tick(5);
        bus.gray_in = 4'b0001;
        tick(1);
        chk("hold5_early", 32'(bus.step_pulse), 32'd0);
        tick(1);
        chk("hold5_pulse", 32'(bus.step_pulse), 32'd1);
        chk("hold5_bin", 32'(bus.binary_out), 32'd2);
        chk("hold5_pos", 32'(bus.position), 32'd2);
        tick(5);
        chk("hold5_back_pulse", 32'(bus.step_pulse), 32'd1);
        chk("hold5_back_bin", 32'(bus.binary_out), 32'd1);
        chk("hold5_back_up", 32'(bus.step_up), 32'd0);
        tick(12);

        // 5: illegal jumps and error saturation
        do_step("to0", 4'b0000, 4'd0, 1'b0, 16'd0);
        bus.gray_in = 4'b0011;
        tick(7);
        chk("jump_errpulse", 32'(bus.error_pulse), 32'd1);
        chk("jump_nostep", 32'(bus.step_pulse), 32'd0);
        chk("jump_bin", 32'(bus.binary_out), 32'd2);
        chk("jump_pos", 32'(bus.position), 32'd0);
        chk("jump_ecnt", 32'(bus.error_count), 32'd1);
        tick(1);
        chk("jump_narrow", 32'(bus.error_pulse), 32'd0);
        tick(12);
        err_seen = 1;
        both_seen = 0;
        step_seen = 0;
        for (int i = 0; i < 299; i++) begin
            bus.gray_in = (i % 2 == 0) ? 4'b0000 : 4'b0011;
            for (int k = 0; k < 5; k++) begin
                tick(1);
                if (bus.error_pulse) err_seen++;
                if (bus.step_pulse) step_seen++;
                if (bus.error_pulse && bus.step_pulse) both_seen++;
            end
        end
        for (int k = 0; k < 10; k++) begin
            tick(1);
            if (bus.error_pulse) err_seen++;
            if (bus.step_pulse) step_seen++;
        end
        chk("sat_errpulses", 32'(err_seen), 32'd300);
        chk("sat_nosteps", 32'(step_seen), 32'd0);
        chk("sat_exclusive", 32'(both_seen), 32'd0);
        chk("sat_ecnt", 32'(bus.error_count), 32'd255);
        chk("sat_pos", 32'(bus.position), 32'd0);
        chk("sat_bin", 32'(bus.binary_out), 32'd0);

        // 6: clear coincident with an up step at position 5
        do_step("c1", 4'b0001, 4'd1, 1'b1, 16'd1);
        do_step("c2", 4'b0011, 4'd2, 1'b1, 16'd2);
        do_step("c3", 4'b0010, 4'd3, 1'b1, 16'd3);
        do_step("c4", 4'b0110, 4'd4, 1'b1, 16'd4);
        do_step("c5", 4'b0111, 4'd5, 1'b1, 16'd5);
        bus.gray_in = 4'b0101;
        tick(6);
        bus.clr_counts = 1'b1;
        tick(1);
        bus.clr_counts = 1'b0;
        chk("clr_step", 32'(bus.step_pulse), 32'd1);
        chk("clr_up", 32'(bus.step_up), 32'd1);
        chk("clr_bin", 32'(bus.binary_out), 32'd6);
        chk("clr_pos", 32'(bus.position), 32'd0);
        chk("clr_ecnt", 32'(bus.error_count), 32'd0);
        chk("clr_valid", 32'(bus.valid), 32'd1);
        tick(12);

        // Reset in the middle of debouncing a new code
        bus.gray_in = 4'b0100;
        tick(4);
        rst = 1'b1;
        tick(1);
        chk_reset_vals("midrst");
        rst = 1'b0;
        tick(6);
        chk("post_rst_e6", 32'(bus.valid), 32'd0);
        tick(1);
        chk("post_rst_valid", 32'(bus.valid), 32'd1);
        chk("post_rst_bin", 32'(bus.binary_out), 32'd7);
        chk("post_rst_nostep", 32'(bus.step_pulse), 32'd0);
        chk("post_rst_pos", 32'(bus.position), 32'd0);
        tick(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
